multi_dff_bank: RTL and testbench
=================================

Name: multi_dff_bank

Overview:
Parametrised multi-word register bank for the memory library: 2**S words of WIDTH bits.
- Supports hold, addressed write, shift-chain (delay line) and clear modes.
- Provides a registered read port with true and complemented outputs.
- Tracks shift fill level.
- Successor to the single-word latch group; edge-triggered, with depth, addressing, mode control and occupancy tracking.

Parameters:
- WIDTH, 8, data word width in bits.
- S, 3, address width; DEPTH = 2**S words.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset at next rising clk edge).
- mode  input  2  operation select: 00 hold, 01 write, 10 shift, 11 clear.
- addr  input  S  read address; also the write address in mode 01.
- in  input  WIDTH  write / shift-in data.
- out1  output  WIDTH  registered read data, word[addr].
- out2  output  WIDTH  registered bitwise complement of out1.
- shout  output  WIDTH  registered word shifted out of word[DEPTH-1].
- count  output  S+1  number of words shifted in since last clear/reset, saturating at DEPTH.
- full  output  1  count == DEPTH (combinational from count).

Behaviour:
- Reset (reset==0 at rising edge) has priority over mode. Next state:
  - all words 0, out1 = 0, out2 = all ones, shout = 0, count = 0, full = 0.
- All other updates occur on the rising edge with reset==1.
- Read: every cycle out1 <= word[addr] and out2 <= ~word[addr], using contents before this edge's update (read-before-write). Latency is 1 cycle from addr.
- Mode 00 hold: words, count and shout unchanged; read still updates.
- Mode 01 write: word[addr] <= in. Other words, count and shout unchanged.
  - Same-cycle read of addr returns the old value; the new value appears on out1 one edge later if addr is held.
- Mode 10 shift:
  - word[0] <= in; word[i] <= word[i-1] for i = 1..DEPTH-1.
  - shout <= old word[DEPTH-1].
  - count <= count+1 if count < DEPTH, else stays DEPTH (no wrap).
  - addr is ignored for the update; the read uses pre-shift contents.
- Mode 11 clear: all words <= 0, count <= 0, shout <= 0. out1/out2 capture pre-clear contents this edge and show 0 / all ones from the next edge onward.
- shout holds its last value in modes 00 and 01.
- count is unaffected by mode 01; written words do not count as fill.
- DEPTH=1 (S=0) is legal: addr is 1 bit wide and ignored; shift makes word[0] <= in and shout <= old word[0].
- No X propagation: every register has a defined reset value. Unknown or undriven mode is not a legal input.

Decomposition:
- Shared memory package holds:
  - mode encodings MODE_HOLD=2'b00, MODE_WRITE=2'b01, MODE_SHIFT=2'b10, MODE_CLEAR=2'b11;
  - localparam DEPTH derivation.
- One natural sub-module: dff_word.
  - A WIDTH-bit register with synchronous active-low reset and a 2-way next-value mux (load data vs chain data) plus enable.
  - Instantiated DEPTH times by generate.
- Top level holds the mode decode, read mux, shout register and saturating counter.

Test Plan (WIDTH=8, S=3):
1. reset=0 for one edge with mode=10, in=125 → out1=0, out2=255, shout=0, count=0, full=0; no word captures 125.
2. reset=1, mode=01, addr=5, in=125 for one edge, then mode=00, addr=5 → out1=125, out2=130 after the second edge; words other than 5 read 0.
3. mode=10 with in=1..8 on 8 consecutive edges → count=8, full=1; reading addr 0..7 gives 8,7,…,1. A 9th shift with in=9 → shout=1, count stays 8, word[0]=9.
4. word[2]=40; mode=01, addr=2, in=77 → out1=40 at that edge; holding addr=2 → out1=77 at the next edge.
5. After scenario 3, mode=11 for one edge → count=0, full=0, shout=0; reading any addr on later edges gives out1=0, out2=255.
6. Mid-shift (count=4), reset=0 for one edge with mode=10 → all words 0, count=0, shout=0; reset wins over shift.

Source files
------------

// File: rtl/multi_dff_bank_pkg.sv
// Shared definitions for the multi-word register bank: mode encodings and size helpers.
package multi_dff_bank_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_S     = 3;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_WRITE = 2'b01,
        MODE_SHIFT = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_e;

    // Number of words held for a given address width.
    function automatic int unsigned depth_of(input int unsigned s);
        return 32'd1 << s;
    endfunction

    // Address port keeps at least one bit so a single-word bank still has a port.
    function automatic int unsigned addr_w(input int unsigned s);
        return (s == 0) ? 32'd1 : s;
    endfunction

endpackage

// File: rtl/multi_dff_bank_if.sv
// Control/data bundle for the register bank: mode, address and data in, read/shift/fill status out.
interface multi_dff_bank_if
    import multi_dff_bank_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned S     = DEF_S
);
    localparam int unsigned AW = addr_w(S);
    localparam int unsigned CW = S + 1;

    logic [1:0]       mode;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] shout;
    logic [CW-1:0]    count;
    logic             full;

    modport master (
        output mode, addr, in,
        input  out1, out2, shout, count, full
    );

    modport slave (
        input  mode, addr, in,
        output out1, out2, shout, count, full
    );

endinterface

// File: rtl/multi_dff_bank_dff_word.sv
// One storage word: enabled register choosing between load data and the shift-chain neighbour.
module multi_dff_bank_dff_word
    import multi_dff_bank_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sel_chain,
    input  logic [WIDTH-1:0] load_data,
    input  logic [WIDTH-1:0] chain_data,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = sel_chain ? chain_data : load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/multi_dff_bank.sv
// Register bank of 2**S words with hold/write/shift/clear modes, registered read port,
// shift-out register and saturating fill counter.
module multi_dff_bank
    import multi_dff_bank_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned S     = DEF_S
) (
    input  logic          clk,
    input  logic          reset,
    multi_dff_bank_if.slave bus
);

    localparam int unsigned DEPTH = depth_of(S);
    localparam int unsigned AW    = addr_w(S);
    localparam int unsigned CW    = S + 1;

    mode_e            mode_c;
    logic             is_write;
    logic             is_shift;
    logic             is_clear;
    logic [WIDTH-1:0] load_data;
    logic [DEPTH-1:0] addr_hit;
    logic [WIDTH-1:0] word_q [DEPTH];
    logic [WIDTH-1:0] rd_acc [DEPTH];
    logic [WIDTH-1:0] rd_data;

    logic [WIDTH-1:0] out1_d,  out1_q;
    logic [WIDTH-1:0] out2_d,  out2_q;
    logic [WIDTH-1:0] shout_d, shout_q;
    logic [CW-1:0]    count_d, count_q;

    // Mode decode
    always_comb begin
        mode_c   = mode_e'(bus.mode);
        is_write = 1'b0;
        is_shift = 1'b0;
        is_clear = 1'b0;
        unique case (mode_c)
            MODE_WRITE: is_write = 1'b1;
            MODE_SHIFT: is_shift = 1'b1;
            MODE_CLEAR: is_clear = 1'b1;
            default:    ;
        endcase
    end

    // Clear reuses the load path with zero data.
    assign load_data = is_clear ? '0 : bus.in;

    // Word array, address decode and one-hot read OR-tree
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [WIDTH-1:0] chain_data;
        logic [WIDTH-1:0] rd_mask;

        if (S == 0) begin : g_hit
            assign addr_hit[i] = 1'b1;
        end else begin : g_hit
            assign addr_hit[i] = (bus.addr == AW'(i));
        end

        if (i == 0) begin : g_chain
            assign chain_data = bus.in;
        end else begin : g_chain
            assign chain_data = word_q[i-1];
        end

        multi_dff_bank_dff_word #(
            .WIDTH (WIDTH)
        ) u_word (
            .clk        (clk),
            .reset      (reset),
            .en         (is_clear | is_shift | (is_write & addr_hit[i])),
            .sel_chain  (is_shift),
            .load_data  (load_data),
            .chain_data (chain_data),
            .q          (word_q[i])
        );

        assign rd_mask = addr_hit[i] ? word_q[i] : '0;

        if (i == 0) begin : g_rd
            assign rd_acc[i] = rd_mask;
        end else begin : g_rd
            assign rd_acc[i] = rd_acc[i-1] | rd_mask;
        end
    end

    assign rd_data = rd_acc[DEPTH-1];

    // Next-state for read port, shift-out and fill counter
    always_comb begin
        out1_d  = rd_data;
        out2_d  = ~rd_data;
        shout_d = shout_q;
        count_d = count_q;
        if (is_shift) begin
            shout_d = word_q[DEPTH-1];
            if (count_q < CW'(DEPTH)) begin
                count_d = count_q + CW'(1);
            end
        end else if (is_clear) begin
            shout_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out1_q  <= '0;
            out2_q  <= '1;
            shout_q <= '0;
            count_q <= '0;
        end else begin
            out1_q  <= out1_d;
            out2_q  <= out2_d;
            shout_q <= shout_d;
            count_q <= count_d;
        end
    end

    assign bus.out1  = out1_q;
    assign bus.out2  = out2_q;
    assign bus.shout = shout_q;
    assign bus.count = count_q;
    assign bus.full  = (count_q == CW'(DEPTH));

endmodule

// File: tb/tb_multi_dff_bank.sv
// Randomised and directed bench for multi_dff_bank against an array-based behavioural model.
module tb_multi_dff_bank;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned S     = 3;
    localparam int          DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    multi_dff_bank_if #(.WIDTH(WIDTH), .S(S)) bus ();

    multi_dff_bank #(.WIDTH(WIDTH), .S(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [7:0] m_mem [DEPTH];
    logic [7:0] m_out1;
    logic [7:0] m_out2;
    logic [7:0] m_shout;
    int         m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model by one edge, then compare all outputs.
    task automatic step(input string tag, input logic rst, input logic [1:0] md,
                        input logic [2:0] a, input logic [7:0] d);
        reset    = rst;
        bus.mode = md;
        bus.addr = a;
        bus.in   = d;
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
            m_out1  = 8'h00;
            m_out2  = 8'hff;
            m_shout = 8'h00;
            m_count = 0;
        end else begin
            m_out1 = m_mem[a];
            m_out2 = ~m_mem[a];
            case (md)
                2'b01: m_mem[a] = d;
                2'b10: begin
                    m_shout = m_mem[DEPTH-1];
                    for (int i = DEPTH - 1; i > 0; i--) m_mem[i] = m_mem[i-1];
                    m_mem[0] = d;
                    if (m_count < DEPTH) m_count++;
                end
                2'b11: begin
                    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
                    m_shout = 8'h00;
                    m_count = 0;
                end
                default: ;
            endcase
        end
        #1;
        check({tag, ".out1"},  32'(bus.out1),  32'(m_out1));
        check({tag, ".out2"},  32'(bus.out2),  32'(m_out2));
        check({tag, ".shout"}, 32'(bus.shout), 32'(m_shout));
        check({tag, ".count"}, 32'(bus.count), 32'(m_count));
        check({tag, ".full"},  32'(bus.full),  (m_count == DEPTH) ? 32'd1 : 32'd0);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
        m_out1 = 8'h00; m_out2 = 8'hff; m_shout = 8'h00; m_count = 0;
        bus.mode = 2'b00; bus.addr = 3'd0; bus.in = 8'd0;
        @(negedge clk);

        // 1: reset beats shift
        step("s1_rst", 1'b0, 2'b10, 3'd0, 8'd125);
        check("s1_out1", 32'(bus.out1), 32'd0);
        check("s1_out2", 32'(bus.out2), 32'd255);
        check("s1_count", 32'(bus.count), 32'd0);
        for (int a = 0; a < DEPTH; a++) step("s1_rd", 1'b1, 2'b00, 3'(a), 8'd0);

        // 2: addressed write then read-back
        step("s2_wr", 1'b1, 2'b01, 3'd5, 8'd125);
        step("s2_hold", 1'b1, 2'b00, 3'd5, 8'd0);
        check("s2_out1", 32'(bus.out1), 32'd125);
        check("s2_out2", 32'(bus.out2), 32'd130);
        step("s2_rd4", 1'b1, 2'b00, 3'd4, 8'd0);
        check("s2_other", 32'(bus.out1), 32'd0);

        // 3: fill the delay line, then one more shift
        step("s3_clr", 1'b1, 2'b11, 3'd0, 8'd0);
        for (int k = 1; k <= DEPTH; k++) step("s3_sh", 1'b1, 2'b10, 3'd0, 8'(k));
        check("s3_count", 32'(bus.count), 32'd8);
        check("s3_full", 32'(bus.full), 32'd1);
        for (int a = 0; a < DEPTH; a++) begin
            step("s3_rd", 1'b1, 2'b00, 3'(a), 8'd0);
            check("s3_word", 32'(bus.out1), 32'(DEPTH - a));
        end
        step("s3_sh9", 1'b1, 2'b10, 3'd0, 8'd9);
        check("s3_shout", 32'(bus.shout), 32'd1);
        check("s3_sat", 32'(bus.count), 32'd8);
        step("s3_rd0", 1'b1, 2'b00, 3'd0, 8'd0);
        check("s3_w0", 32'(bus.out1), 32'd9);

        // 5: clear after full
        step("s5_clr", 1'b1, 2'b11, 3'd3, 8'd0);
        check("s5_count", 32'(bus.count), 32'd0);
        check("s5_shout", 32'(bus.shout), 32'd0);
        check("s5_pre", 32'(bus.out1), 32'd6);
        step("s5_rd", 1'b1, 2'b00, 3'd3, 8'd0);
        check("s5_out1", 32'(bus.out1), 32'd0);
        check("s5_out2", 32'(bus.out2), 32'd255);

        // 4: read-before-write on the same address
        step("s4_w40", 1'b1, 2'b01, 3'd2, 8'd40);
        step("s4_w77", 1'b1, 2'b01, 3'd2, 8'd77);
        check("s4_old", 32'(bus.out1), 32'd40);
        step("s4_hold", 1'b1, 2'b00, 3'd2, 8'd0);
        check("s4_new", 32'(bus.out1), 32'd77);

        // 6: reset in the middle of shifting
        step("s6_clr", 1'b1, 2'b11, 3'd0, 8'd0);
        for (int k = 0; k < 4; k++) step("s6_sh", 1'b1, 2'b10, 3'd0, 8'(8'hA0 + k));
        check("s6_mid", 32'(bus.count), 32'd4);
        step("s6_rst", 1'b0, 2'b10, 3'd0, 8'hEE);
        check("s6_count", 32'(bus.count), 32'd0);
        for (int a = 0; a < DEPTH; a++) step("s6_rd", 1'b1, 2'b00, 3'(a), 8'd0);

        // Random traffic with occasional resets
        for (int n = 0; n < 500; n++) begin
            int unsigned r;
            logic [1:0]  md;
            r  = $urandom_range(0, 9);
            md = (r < 2) ? 2'b00 : (r < 5) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            step("rnd", ($urandom_range(0, 39) != 0), md, 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 255)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
